tap_delay_line: RTL
===================

Name: tap_delay_line

Overview:
- Parameterised tapped delay line built from enable-gated register slices.
- Sits directly downstream of single-bit/word pipeline flops, and upstream of the FIR multiply-accumulate stage.
- Accepts one sample per valid/ready handshake, shifts it into a NUM_TAPS-deep chain, and presents all taps in parallel with an output valid/ready handshake.
- Tracks fill state so the MAC only sees a primed window.

Parameters:
- DATA_W, 16, sample width in bits.
- NUM_TAPS, 8, delay-line depth. Legal range is 2..64.
- CNT_W, $clog2(NUM_TAPS+1), fill counter width. Derived; not overridden.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream sample valid.
- in_ready, output, 1: block can accept a sample.
- in_data, input, DATA_W: sample; treated as opaque bits.
- flush, input, 1: clear the window; single-cycle pulse.
- taps, output, DATA_W*NUM_TAPS: tap k is at bits [k*DATA_W +: DATA_W]; tap 0 is the newest sample.
- taps_valid, output, 1: taps window valid for the MAC.
- taps_ready, input, 1: MAC consumes the window.
- fill_count, output, CNT_W: number of real samples in the chain, saturating at NUM_TAPS.
- primed, output, 1: high when fill_count == NUM_TAPS.

Behaviour:
- Reset (rst sampled high at posedge):
  - All taps = 0.
  - taps_valid = 0, fill_count = 0, primed = 0.
  - State = EMPTY.
  - in_ready = 1 from the first cycle after reset.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Window consumed when taps_valid && taps_ready.
  - in_ready = !taps_valid || taps_ready. This is combinational, with no bubble when the MAC is always ready.
- Shift on accept: tap[k] <= tap[k-1] for k >= 1, and tap[0] <= in_data. Taps update 1 cycle after the accept edge.
- fill_count increments on accept and saturates at NUM_TAPS.
- taps_valid:
  - Set the cycle after an accept that leaves fill_count == NUM_TAPS.
  - Held, with the window frozen, until consumed.
  - Consume and accept in the same cycle: taps_valid stays 1 and the new window appears.
  - Consume only: taps_valid clears.
- States:
  - EMPTY (count 0) -> FILLING on accept.
  - FILLING -> PRIMED when count reaches NUM_TAPS.
  - PRIMED stays PRIMED on further accepts (sliding window).
  - Any state -> EMPTY on flush.
- flush:
  - Zeroes all taps, count, and taps_valid on the next edge.
  - Has priority over a simultaneous accept; that sample is dropped.
  - in_ready is forced to 0 in the flush cycle.
- Reset has priority over flush and accept. A reset mid-fill discards partial state.
- Backpressure: with taps_valid high and taps_ready low, in_ready = 0. The chain and count are frozen; no sample is lost or duplicated.
- No arithmetic is performed on data and no width changes occur.

Optional Feature:
- Macro TAP_DELAY_ZERO_FILL_EN.
- When defined:
  - taps_valid is set after every accept, including while FILLING.
  - Unfilled taps read as 0, giving the FIR a zero-initial-condition start-up transient.
  - primed and fill_count behave unchanged.
- When undefined: taps_valid is only asserted in PRIMED, as described above.

Decomposition:
- Package tap_delay_pkg holds:
  - state enum {EMPTY, FILLING, PRIMED}, 2-bit;
  - default DATA_W / NUM_TAPS localparams;
  - a tap-index helper function.
- One sub-module, tap_reg_slice: a DATA_W register with synchronous active-high rst and en.
  - Instantiated NUM_TAPS times via generate.
  - Its d input is in_data for slice 0 and the previous slice for all others.

Test Plan:
- Reset then fill, NUM_TAPS=8, taps_ready=1: drive 1..8 on consecutive cycles. taps_valid first rises the cycle after sample 8 is accepted; window is taps = {1,2,3,4,5,6,7,8} from tap 7 down to tap 0; primed = 1, fill_count = 8.
- Sliding window: continue with 9, 10. Windows read tap0 = 9 with tap7 = 2, then tap0 = 10 with tap7 = 3. in_ready stays 1 throughout.
- Backpressure: hold taps_ready = 0 for 4 cycles with in_valid = 1. in_ready = 0 and the window is frozen. On release, the next sample enters; no drop, no duplicate.
- Flush with accept: assert flush and in_valid (data 0xABCD) in the same cycle. Next cycle all taps = 0, fill_count = 0, taps_valid = 0. 0xABCD is not present.
- Mid-fill reset: after 3 samples, pulse rst. fill_count = 0. A further 8 samples are required before taps_valid.
- With TAP_DELAY_ZERO_FILL_EN: drive a single sample 5. taps_valid = 1 next cycle with tap0 = 5 and taps 1..7 = 0; primed = 0, fill_count = 1.

Source files
------------

// File: rtl/tap_delay_pkg.sv
// tap_delay_pkg: shared types and defaults for the tapped delay line.
// Holds the fill-state enum, default geometry and the tap bit-offset helper.
// No ports; imported by tap_reg_slice and tap_delay_line.
package tap_delay_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } tap_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_TAPS = 8;

    // LSB position of tap k inside the flattened taps bus.
    function automatic int tap_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/tap_reg_slice.sv
// tap_reg_slice: one DATA_W-wide stage of the delay line.
// Ports: clk, rst (sync, active-high, clears q), en (load d), d, q.
// Single-cycle register; holds its value whenever en is low.
module tap_reg_slice
    import tap_delay_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tap_delay_line.sv
// tap_delay_line: NUM_TAPS-deep shift chain presenting all taps in parallel to a MAC.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data sample input; flush pulse;
//        taps/taps_valid/taps_ready window output; fill_count and primed status.
// Taps update 1 cycle after accept; in_ready = !flush && (!taps_valid || taps_ready).
// Optional build macro TAP_DELAY_ZERO_FILL_EN: raise taps_valid after every accept,
// unfilled taps reading as 0 (zero-initial-condition start-up).
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_TAPS = DEF_NUM_TAPS,
    localparam int CNT_W    = $clog2(NUM_TAPS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       flush,
    output logic [DATA_W*NUM_TAPS-1:0] taps,
    output logic                       taps_valid,
    input  logic                       taps_ready,
    output logic [CNT_W-1:0]           fill_count,
    output logic                       primed
);

`ifdef TAP_DELAY_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);

    tap_state_t state;
    logic       accept;
    logic       consume;
    logic       slice_clr;
    logic       fills_window;

    logic [DATA_W-1:0] tap_q [NUM_TAPS];

    // Flush blocks acceptance outright so the dropped sample never reaches the chain.
    assign in_ready     = !flush && (!taps_valid || taps_ready);
    assign accept       = in_valid && in_ready;
    assign consume      = taps_valid && taps_ready;
    assign slice_clr    = rst || flush;
    // This accept completes (or keeps) a full window.
    assign fills_window = (fill_count >= CNT_LAST);

    genvar k;
    generate
        for (k = 0; k < NUM_TAPS; k++) begin : g_tap
            logic [DATA_W-1:0] slice_d;
            if (k == 0) begin : g_head
                assign slice_d = in_data;
            end else begin : g_body
                assign slice_d = tap_q[k-1];
            end

            tap_reg_slice #(.W(DATA_W)) u_slice (
                .clk (clk),
                .rst (slice_clr),
                .en  (accept),
                .d   (slice_d),
                .q   (tap_q[k])
            );

            assign taps[tap_lsb(k, DATA_W) +: DATA_W] = tap_q[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= EMPTY;
            fill_count <= '0;
            taps_valid <= 1'b0;
            primed     <= 1'b0;
        end else if (accept) begin
            if (fill_count != CNT_FULL) begin
                fill_count <= fill_count + CNT_W'(1);
            end
            // An accept while valid implies a same-cycle consume; the new window replaces it.
            taps_valid <= ZERO_FILL || fills_window;
            case (state)
                EMPTY: begin
                    state <= FILLING;
                end
                FILLING: begin
                    if (fills_window) begin
                        state  <= PRIMED;
                        primed <= 1'b1;
                    end
                end
                PRIMED: begin
                    state <= PRIMED;
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end else if (consume) begin
            taps_valid <= 1'b0;
        end
    end

endmodule
